// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: shows one digit of a double-buffered
// hex value per slot, with anode-off dead time at the start of each slot and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int DEAD     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [3:0]            abcd_q, abcd_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  wrap, boundary;
  logic [3:0]            digit;
  logic                  blanked;
  logic                  upper_zero;

  assign wrap     = (cnt_q == CW'(PRESCALE - 1));
  assign boundary = wrap && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // A load on the boundary cycle bypasses the pending buffer; either way pending is consumed.
  always_comb begin
    pending_d    = load ? value : pending_q;
    pend_vld_d   = load | pend_vld_q;
    shadow_d     = shadow_q;
    frame_tick_d = 1'b0;
    if (boundary) begin
      pend_vld_d   = 1'b0;
      frame_tick_d = load | pend_vld_q;
      if (load)
        shadow_d = value;
      else if (pend_vld_q)
        shadow_d = pending_q;
    end
  end

  // Scan from the top digit down so upper_zero covers digits DIGITS-1..i when i is reached.
  always_comb begin
    digit      = '0;
    blanked    = 1'b0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (shadow_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        digit   = shadow_q[4*i +: 4];
        blanked = blank_lz && (i != 0) && upper_zero;
      end
    end
  end

  always_comb begin
    abcd_d = digit;
    if ((cnt_q < CW'(DEAD)) || blanked)
      an_d = '1;
    else
      an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_vld_q   <= 1'b0;
      abcd_q       <= '0;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_vld_q   <= pend_vld_d;
      abcd_q       <= abcd_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign a          = abcd_q[3];
  assign b          = abcd_q[2];
  assign c          = abcd_q[1];
  assign d          = abcd_q[0];
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, PRESCALE=8, DEAD=2): directed scenarios plus
// randomized traffic compared cycle by cycle with a time-indexed behavioural model.
module tb_seg_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] value;
  logic        a, b, c, d, frame_tick;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  // Model state: t counts non-reset edges since the last reset, so slot position is pure arithmetic.
  int          t;
  logic [15:0] m_shadow, m_pending;
  logic        m_pvld;
  logic [8:0]  exp_o;

  seg_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .a(a), .b(b), .c(c), .d(d), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic bl);
    int   cnt, idx;
    logic bnd, blk, ft;
    logic [3:0] dig, an_e;
    rst = r; load = ld; value = v; blank_lz = bl;
    if (r) begin
      exp_o = {4'hF, 4'h0, 1'b0};
      t = 0; m_shadow = '0; m_pending = '0; m_pvld = 1'b0;
    end else begin
      cnt  = t % PRESCALE;
      idx  = (t / PRESCALE) % DIGITS;
      bnd  = (cnt == PRESCALE - 1) && (idx == DIGITS - 1);
      dig  = 4'((m_shadow >> (4 * idx)) & 16'hF);
      blk  = bl && (idx > 0) && ((m_shadow >> (4 * idx)) == 16'h0);
      an_e = (cnt < DEAD || blk) ? 4'hF : ~(4'b0001 << idx);
      ft   = bnd && (ld || m_pvld);
      exp_o = {an_e, dig, ft};
      if (bnd) begin
        if (ld) m_shadow = v;
        else if (m_pvld) m_shadow = m_pending;
        m_pvld = 1'b0;
        if (ld) m_pending = v;
      end else if (ld) begin
        m_pending = v;
        m_pvld    = 1'b1;
      end
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      total++;
      if ({an, a, b, c, d, frame_tick} !== 9'h1E0) begin
        bad++; $display("FAIL reset_state got=%h exp=%h", {an, a, b, c, d, frame_tick}, 9'h1E0);
      end
    end
    for (int k = 0; k < PRESCALE; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      total++;
      if ({an, a, b, c, d, frame_tick} !== ((k < DEAD) ? 9'h1E0 : 9'h1C0)) begin
        bad++; $display("FAIL first_slot k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick},
                        ((k < DEAD) ? 9'h1E0 : 9'h1C0));
      end
    end
  endtask

  task automatic test_load();
    int ticks = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    for (int k = 1; k < 2 * FRAME + 4; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      ticks += frame_tick;
      total++;
      if ({an, a, b, c, d, frame_tick} !== exp_o) begin
        bad++; $display("FAIL load_1234 k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick}, exp_o);
      end
      if (k == FRAME - 1) begin
        total++;
        if (frame_tick !== 1'b1) begin
          bad++; $display("FAIL tick_cycle32 got=%b exp=1", frame_tick);
        end
      end
      if (k == FRAME + 3 * PRESCALE + DEAD) begin
        total++;
        if ({an, a, b, c, d} !== {4'b0111, 4'h1}) begin
          bad++; $display("FAIL digit3_slot got=%h exp=%h", {an, a, b, c, d}, {4'b0111, 4'h1});
        end
      end
    end
    total++;
    if (ticks != 1) begin
      bad++; $display("FAIL load_tick_count got=%0d exp=1", ticks);
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b1, vals[n], 1'b1);
      for (int k = 0; k < 2 * FRAME; k++) begin
        step(1'b0, 1'b0, 16'h0, 1'b1);
        total++;
        if ({an, a, b, c, d, frame_tick} !== exp_o) begin
          bad++; $display("FAIL blank_lz v=%h k=%0d got=%h exp=%h", vals[n], k,
                          {an, a, b, c, d, frame_tick}, exp_o);
        end
        if (!$isunknown(an) && $countones(~an) > 1) begin
          bad++; $display("FAIL one_anode an=%b exp=at most one low", an);
        end
      end
    end
  endtask

  task automatic test_last_wins();
    int ticks = 0;
    while ((t % FRAME) != 2) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hAAAA, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 1'b0);
    for (int k = 0; k < 2 * FRAME; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      ticks += frame_tick;
      total++;
      if ({an, a, b, c, d, frame_tick} !== exp_o) begin
        bad++; $display("FAIL last_wins k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick}, exp_o);
      end
    end
    total++;
    if (ticks != 1) begin
      bad++; $display("FAIL last_wins_ticks got=%0d exp=1", ticks);
    end
  endtask

  task automatic test_boundary_load();
    while ((t % FRAME) != FRAME - 1) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    total++;
    if (frame_tick !== 1'b1) begin
      bad++; $display("FAIL boundary_tick got=%b exp=1", frame_tick);
    end
    for (int k = 0; k < FRAME + 2; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      total++;
      if ({an, a, b, c, d, frame_tick} !== exp_o) begin
        bad++; $display("FAIL boundary_beef k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick}, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ticks = 0;
    step(1'b0, 1'b1, 16'h9876, 1'b0);
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    total++;
    if ({an, a, b, c, d, frame_tick} !== 9'h1E0) begin
      bad++; $display("FAIL reset_mid got=%h exp=%h", {an, a, b, c, d, frame_tick}, 9'h1E0);
    end
    for (int k = 0; k < FRAME + 8; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      ticks += frame_tick;
      total++;
      if ({an, a, b, c, d, frame_tick} !== exp_o) begin
        bad++; $display("FAIL reset_mid_run k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick}, exp_o);
      end
    end
    total++;
    if (ticks != 0) begin
      bad++; $display("FAIL reset_mid_ticks got=%0d exp=0", ticks);
    end
  endtask

  task automatic test_random();
    logic        ld, bl;
    logic [15:0] v;
    bl = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      ld = ($urandom_range(0, 19) == 0);
      v  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        default: ;
      endcase
      if ($urandom_range(0, 99) == 0) bl = ~bl;
      step(($urandom_range(0, 999) == 0), ld, v, bl);
      total++;
      if ({an, a, b, c, d, frame_tick} !== exp_o) begin
        bad++; $display("FAIL random k=%0d got=%h exp=%h", k, {an, a, b, c, d, frame_tick}, exp_o);
      end
      if (!$isunknown(an) && $countones(~an) > 1) begin
        bad++; $display("FAIL random_one_anode an=%b exp=at most one low", an);
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
    t = 0; m_shadow = '0; m_pending = '0; m_pvld = 1'b0; exp_o = '0;
    #1;
    test_reset();
    test_load();
    test_blank();
    test_last_wins();
    test_boundary_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
